rtc_bus_ctrl: RTL and testbench

- Transaction engine for the external real-time-clock chip's multiplexed 8-bit address/data bus.
- Drives CS, WR, RD and AD, and owns the bidirectional `dato_rtc` pins.
- Upstream, the time-keeping/display logic issues single-register read or write requests over a req/done handshake.
- Each request becomes one address phase followed by one data phase, with programmable setup, strobe and hold widths in clk cycles.

---
 rtl/rtc_pkg.sv | 40 ++++
 rtl/rtc_phase_timer.sv | 26 ++
 rtl/rtc_bus_ctrl.sv | 156 +++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC multiplexed-bus controller.
package rtc_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    A_SET,
    A_PUL,
    A_HLD,
    D_SET,
    D_PUL,
    D_HLD,
    DONE
  } rtc_state_e;

  localparam logic AD_ADDR    = 1'b0;
  localparam logic AD_DATA    = 1'b1;
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } rtc_req_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold the count values 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; tc_c flags the last cycle of the current phase.
module rtc_phase_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Single-register read/write engine for the RTC multiplexed address/data bus.
// Every pin is registered from the next-state decode so strobes never glitch.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD  = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              CS,
  output logic              WR,
  output logic              RD,
  output logic              AD,
  inout  wire  [DATA_W-1:0] dato_rtc
);

  localparam int unsigned T_MAX = max3(T_SETUP, T_PULSE, T_HOLD);
  localparam int unsigned TW    = cnt_width(T_MAX);

  rtc_state_e        state_q, state_d;
  rtc_req_t          txn_q, txn_d;
  logic              load;
  logic [TW-1:0]     load_val;
  logic              tc_c;
  logic              capture_c;
  logic              oe_q;
  logic [DATA_W-1:0] bus_q;

  logic              cs_d, wr_d, rd_d, ad_d, oe_d, busy_d, done_d;
  logic [DATA_W-1:0] bus_d;

  rtc_phase_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .tc_c     (tc_c)
  );

  // Next state, timer reload and next pin values.
  always_comb begin
    state_d  = state_q;
    txn_d    = txn_q;
    load     = 1'b0;
    load_val = '0;
    cs_d     = 1'b1;
    wr_d     = STROBE_OFF;
    rd_d     = STROBE_OFF;
    ad_d     = AD_ADDR;
    oe_d     = 1'b0;
    bus_d    = txn_q.addr;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = A_SET;
          txn_d   = '{we: we, addr: addr, wdata: wdata};
        end
      end
      A_SET: if (tc_c) state_d = A_PUL;
      A_PUL: if (tc_c) state_d = A_HLD;
      A_HLD: if (tc_c) state_d = D_SET;
      D_SET: if (tc_c) state_d = D_PUL;
      D_PUL: if (tc_c) state_d = D_HLD;
      D_HLD: if (tc_c) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      load = 1'b1;
      case (state_d)
        A_SET, D_SET: load_val = TW'(T_SETUP - 1);
        A_PUL, D_PUL: load_val = TW'(T_PULSE - 1);
        A_HLD, D_HLD: load_val = TW'(T_HOLD - 1);
        default:      load_val = '0;
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    bus_d  = txn_d.addr;

    // The address is latched by WR for reads too; a read never drives the data phase.
    case (state_d)
      A_SET, A_HLD: begin
        cs_d = 1'b0;
        oe_d = 1'b1;
      end
      A_PUL: begin
        cs_d = 1'b0;
        oe_d = 1'b1;
        wr_d = STROBE_ON;
      end
      D_SET, D_HLD: begin
        cs_d  = 1'b0;
        ad_d  = AD_DATA;
        oe_d  = txn_d.we;
        bus_d = txn_d.wdata;
      end
      D_PUL: begin
        cs_d  = 1'b0;
        ad_d  = AD_DATA;
        oe_d  = txn_d.we;
        bus_d = txn_d.wdata;
        if (txn_d.we) wr_d = STROBE_ON;
        else          rd_d = STROBE_ON;
      end
      default: ;
    endcase
  end

  assign capture_c = (state_q == D_PUL) && tc_c && !txn_q.we;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      txn_q   <= '0;
      CS      <= 1'b1;
      WR      <= STROBE_OFF;
      RD      <= STROBE_OFF;
      AD      <= AD_ADDR;
      oe_q    <= 1'b0;
      bus_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      CS      <= cs_d;
      WR      <= wr_d;
      RD      <= rd_d;
      AD      <= ad_d;
      oe_q    <= oe_d;
      bus_q   <= bus_d;
      busy    <= busy_d;
      done    <= done_d;
      if (capture_c) rdata <= dato_rtc;
    end
  end

  assign dato_rtc = oe_q ? bus_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench: u0 uses default timing with an RTC register model on its bus,
// u1 uses single-cycle phases on a bare pulled-up bus.
module tb_rtc_bus_ctrl;

  typedef struct packed {
    logic       cs, wr, rd, ad, busy, done;
    logic [7:0] bus;
  } obs_t;

  typedef struct {
    int         e;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdval;
    int         abort_at;
  } tx_t;

  typedef struct {
    int         cyc;
    logic [7:0] rdata;
  } dexp_t;

  localparam obs_t IDLE_OBS = '{cs: 1'b1, wr: 1'b1, rd: 1'b1, ad: 1'b0,
                                busy: 1'b0, done: 1'b0, bus: 8'hFF};

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = 8'h00, wdata0 = 8'h00, addr1 = 8'h00, wdata1 = 8'h00;
  logic       busy0, done0, CS0, WR0, RD0, AD0;
  logic       busy1, done1, CS1, WR1, RD1, AD1;
  logic [7:0] rdata0, rdata1;
  wire  [7:0] bus0, bus1;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic chk_en = 1'b0;

  tx_t   txq0[$], txq1[$];
  dexp_t dq0[$], dq1[$];
  obs_t  e0, e1;
  dexp_t d0, d1;

  logic [7:0] mem [256];
  logic [7:0] rtc_addr;

  rtc_bus_ctrl u0 (
    .clk(clk), .clr(clr), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .busy(busy0), .done(done0), .rdata(rdata0),
    .CS(CS0), .WR(WR0), .RD(RD0), .AD(AD0), .dato_rtc(bus0)
  );

  rtc_bus_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) u1 (
    .clk(clk), .clr(clr), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .rdata(rdata1),
    .CS(CS1), .WR(WR1), .RD(RD1), .AD(AD1), .dato_rtc(bus1)
  );

  pullup (bus0);
  pullup (bus1);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC chip model: WR latches address (AD=0) or data (AD=1); drives only while RD is low.
  assign bus0 = (RD0 == 1'b0) ? mem[rtc_addr] : 8'hzz;

  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0]   <= 8'h59;
      rtc_addr <= 8'h00;
    end else if (WR0 == 1'b0) begin
      if (AD0 == 1'b0) rtc_addr <= bus0;
      else             mem[rtc_addr] <= bus0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Expected pins k cycles after the accepting edge, for phase widths s/p/h.
  function automatic obs_t exp_obs(input tx_t t, input int k, input int s, input int p,
                                   input int h);
    obs_t o;
    int   dn;
    logic in_pul;
    o  = IDLE_OBS;
    dn = 2 * (s + p + h);
    if (k >= 0 && k <= dn) begin
      o.busy = 1'b1;
      if (k == dn) begin
        o.done = 1'b1;
      end else begin
        o.cs = 1'b0;
        if (k < s + p + h) begin
          o.bus = t.addr;
          if (k >= s && k < s + p) o.wr = 1'b0;
        end else begin
          o.ad   = 1'b1;
          in_pul = (k >= 2 * s + p + h) && (k < 2 * s + 2 * p + h);
          if (t.we) begin
            o.bus = t.wdata;
            if (in_pul) o.wr = 1'b0;
          end else if (in_pul) begin
            o.rd  = 1'b0;
            o.bus = t.rdval;
          end
        end
      end
    end
    return o;
  endfunction

  function automatic logic tx_over(input tx_t t, input int c, input int dn);
    return (c > t.e + dn) || (t.abort_at >= 0 && c >= t.abort_at);
  endfunction

  // Monitor: per-cycle pin check, and done/rdata scoreboard pop whenever done is seen.
  always @(negedge clk) begin
    if (chk_en) begin
      while (txq0.size() > 0 && tx_over(txq0[0], cyc, 16)) void'(txq0.pop_front());
      e0 = (txq0.size() > 0 && cyc >= txq0[0].e) ? exp_obs(txq0[0], cyc - txq0[0].e, 2, 4, 2)
                                                  : IDLE_OBS;
      check("u0_pins", 32'({CS0, WR0, RD0, AD0, busy0, done0, bus0}), 32'(e0));
      if (done0) begin
        check("u0_done_pending", 32'(dq0.size() > 0), 32'(1));
        if (dq0.size() > 0) begin
          d0 = dq0.pop_front();
          check("u0_done_cycle", 32'(cyc), 32'(d0.cyc));
          check("u0_rdata", 32'(rdata0), 32'(d0.rdata));
        end
      end

      while (txq1.size() > 0 && tx_over(txq1[0], cyc, 6)) void'(txq1.pop_front());
      e1 = (txq1.size() > 0 && cyc >= txq1[0].e) ? exp_obs(txq1[0], cyc - txq1[0].e, 1, 1, 1)
                                                  : IDLE_OBS;
      check("u1_pins", 32'({CS1, WR1, RD1, AD1, busy1, done1, bus1}), 32'(e1));
      if (done1) begin
        check("u1_done_pending", 32'(dq1.size() > 0), 32'(1));
        if (dq1.size() > 0) begin
          d1 = dq1.pop_front();
          check("u1_done_cycle", 32'(cyc), 32'(d1.cyc));
          check("u1_rdata", 32'(rdata1), 32'(d1.rdata));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // e is the accepting posedge count; done is visible one full cycle later, offset 2*(S+P+H).
  task automatic push0(input int e, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rv, input int ab, input logic [7:0] exp_rd);
    tx_t   t;
    dexp_t x;
    t = '{e: e, we: w, addr: a, wdata: d, rdval: rv, abort_at: ab};
    txq0.push_back(t);
    if (ab < 0) begin
      x = '{cyc: e + 16, rdata: exp_rd};
      dq0.push_back(x);
    end
  endtask

  task automatic push1(input int e, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rv, input logic [7:0] exp_rd);
    tx_t   t;
    dexp_t x;
    t = '{e: e, we: w, addr: a, wdata: d, rdval: rv, abort_at: -1};
    txq1.push_back(t);
    x = '{cyc: e + 6, rdata: exp_rd};
    dq1.push_back(x);
  endtask

  initial begin
    int e;

    // Power-on reset.
    clr = 1'b1;
    tick(3);
    clr    = 1'b0;
    chk_en = 1'b1;
    check("reset_rdata0", 32'(rdata0), 32'(0));
    check("reset_rdata1", 32'(rdata1), 32'(0));

    // Read of 0x00 aborted by a 3-cycle clr in the middle of D_PUL (RD low at offsets 10..13).
    e = cyc + 1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h77;
    push0(e, 1'b0, 8'h00, 8'h77, 8'h59, e + 12, 8'h00);
    tick(1);
    req0 = 1'b0;
    tick(e + 11 - cyc);
    clr = 1'b1;
    tick(3);
    clr = 1'b0;
    check("abort_rdata_kept", 32'(rdata0), 32'(0));
    tick(2);

    // Write 0x26 to register 0x0A; inputs change right after acceptance.
    e = cyc + 1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h0A; wdata0 = 8'h26;
    push0(e, 1'b1, 8'h0A, 8'h26, 8'hFF, -1, 8'h00);
    tick(1);
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'hFF; wdata0 = 8'h00;
    tick(20);

    // Read register 0x00 (model holds 0x59).
    e = cyc + 1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
    push0(e, 1'b0, 8'h00, 8'h00, 8'h59, -1, 8'h59);
    tick(1);
    req0 = 1'b0;
    tick(20);
    check("read_rdata_held", 32'(rdata0), 32'(8'h59));

    // Back-to-back with req held: write(0x01,0x12) then read(0x01), accepted 18 edges apart.
    e = cyc + 1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdata0 = 8'h12;
    push0(e, 1'b1, 8'h01, 8'h12, 8'hFF, -1, 8'h59);
    tick(1);
    we0 = 1'b0; wdata0 = 8'h00;
    push0(e + 18, 1'b0, 8'h01, 8'h00, 8'h12, -1, 8'h12);
    tick(18);
    req0 = 1'b0;
    tick(20);
    check("b2b_rdata", 32'(rdata0), 32'(8'h12));

    // Single-cycle phases: write, then read of the undriven (pulled-up) bus.
    e = cyc + 1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h33; wdata1 = 8'hC4;
    push1(e, 1'b1, 8'h33, 8'hC4, 8'hFF, 8'h00);
    tick(1);
    req1 = 1'b0;
    tick(10);
    e = cyc + 1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
    push1(e, 1'b0, 8'h05, 8'h00, 8'hFF, 8'hFF);
    tick(1);
    req1 = 1'b0;
    tick(10);
    check("sweep_rdata", 32'(rdata1), 32'(8'hFF));

    tick(3);
    check("u0_done_drained", 32'(dq0.size()), 32'(0));
    check("u1_done_drained", 32'(dq1.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
